// File: rtl/mult_hilo_ctrl.sv
// mult_hilo_ctrl
// EX-stage sequencer for an iterative unsigned multiplier and owner of the
// architectural HI/LO registers. A MULTU starts a fixed-latency run of the
// multiplier enable. The 2*WIDTH product is captured into HI/LO on the edge
// that ends the single DONE cycle. While a multiply is in flight, any HI/LO
// op is held off with a combinational stall, so no op is ever dropped.

module mult_hilo_ctrl #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 34
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               op_valid,
  input  logic [2:0]         op_code,
  input  logic [WIDTH-1:0]   op_rs,
  input  logic [WIDTH-1:0]   op_rt,
  output logic               stall,
  output logic               busy,
  output logic               mul_en,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  input  logic [2*WIDTH-1:0] mul_product,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo,
  output logic               rd_valid,
  output logic [WIDTH-1:0]   rd_data
);

  localparam int CW = $clog2(MUL_LAT + 1);

  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_MTHI  = 3'b010;
  localparam logic [2:0] OP_MTLO  = 3'b011;
  localparam logic [2:0] OP_MFHI  = 3'b100;
  localparam logic [2:0] OP_MFLO  = 3'b101;

  localparam logic [CW-1:0] CNT_LAST = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // True for the five op codes that touch HI/LO or the multiplier
  function automatic logic is_hilo_op(input logic [2:0] code);
    logic known;
    case (code)
      OP_MULTU, OP_MTHI, OP_MTLO, OP_MFHI, OP_MFLO: known = 1'b1;
      default:                                      known = 1'b0;
    endcase
    return known;
  endfunction

  state_t           state_r, state_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic             mul_en_r, mul_en_s;
  logic [WIDTH-1:0] mul_a_r, mul_a_s;
  logic [WIDTH-1:0] mul_b_r, mul_b_s;
  logic [WIDTH-1:0] hi_r, hi_s;
  logic [WIDTH-1:0] lo_r, lo_s;
  logic             rd_valid_r, rd_valid_s;
  logic [WIDTH-1:0] rd_data_r, rd_data_s;
  logic             busy_s;
  logic             stall_s;

  assign busy_s  = (state_r != IDLE);
  assign stall_s = op_valid & busy_s & is_hilo_op(op_code);

  assign stall    = stall_s;
  assign busy     = busy_s;
  assign mul_en   = mul_en_r;
  assign mul_a    = mul_a_r;
  assign mul_b    = mul_b_r;
  assign hi       = hi_r;
  assign lo       = lo_r;
  assign rd_valid = rd_valid_r;
  assign rd_data  = rd_data_r;

  // Next-state and next-register values for the sequencer and HI/LO file
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    mul_en_s   = mul_en_r;
    mul_a_s    = mul_a_r;
    mul_b_s    = mul_b_r;
    hi_s       = hi_r;
    lo_s       = lo_r;
    rd_valid_s = 1'b0;
    rd_data_s  = rd_data_r;

    case (state_r)
      IDLE: begin
        mul_en_s = 1'b0;
        if (op_valid) begin
          case (op_code)
            OP_MULTU: begin
              mul_a_s  = op_rs;
              mul_b_s  = op_rt;
              mul_en_s = 1'b1;
              cnt_s    = {CW{1'b0}};
              state_s  = RUN;
            end
            OP_MTHI: hi_s = op_rs;
            OP_MTLO: lo_s = op_rs;
            OP_MFHI: begin
              rd_data_s  = hi_r;
              rd_valid_s = 1'b1;
            end
            OP_MFLO: begin
              rd_data_s  = lo_r;
              rd_valid_s = 1'b1;
            end
            default: begin
              state_s = IDLE;
            end
          endcase
        end else begin
          state_s = IDLE;
        end
      end

      RUN: begin
        mul_en_s = 1'b1;
        cnt_s    = cnt_r + CNT_ONE;
        if (cnt_r == CNT_LAST) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end

      // Product is stable during DONE; capture it and drop the enable
      DONE: begin
        hi_s     = mul_product[2*WIDTH-1:WIDTH];
        lo_s     = mul_product[WIDTH-1:0];
        mul_en_s = 1'b0;
        state_s  = IDLE;
      end

      default: begin
        mul_en_s = 1'b0;
        state_s  = IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously on rst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= {CW{1'b0}};
      mul_en_r   <= 1'b0;
      mul_a_r    <= {WIDTH{1'b0}};
      mul_b_r    <= {WIDTH{1'b0}};
      hi_r       <= {WIDTH{1'b0}};
      lo_r       <= {WIDTH{1'b0}};
      rd_valid_r <= 1'b0;
      rd_data_r  <= {WIDTH{1'b0}};
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      mul_en_r   <= mul_en_s;
      mul_a_r    <= mul_a_s;
      mul_b_r    <= mul_b_s;
      hi_r       <= hi_s;
      lo_r       <= lo_s;
      rd_valid_r <= rd_valid_s;
      rd_data_r  <= rd_data_s;
    end
  end

endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// tb_mult_hilo_ctrl
// Directed bench with a scoreboard: stimulus tasks push hand-computed
// expected read data and products into queues, and a monitor pops and compares
// them when rd_valid pulses or when busy falls.

module tb_mult_hilo_ctrl;

  localparam int WIDTH   = 32;
  localparam int MUL_LAT = 34;

  localparam logic [2:0] OP_NONE  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_MTHI  = 3'b010;
  localparam logic [2:0] OP_MTLO  = 3'b011;
  localparam logic [2:0] OP_MFHI  = 3'b100;
  localparam logic [2:0] OP_MFLO  = 3'b101;
  localparam logic [2:0] OP_R6    = 3'b110;
  localparam logic [2:0] OP_R7    = 3'b111;

  logic               clk;
  logic               rst;
  logic               op_valid;
  logic [2:0]         op_code;
  logic [WIDTH-1:0]   op_rs;
  logic [WIDTH-1:0]   op_rt;
  logic               stall;
  logic               busy;
  logic               mul_en;
  logic [WIDTH-1:0]   mul_a;
  logic [WIDTH-1:0]   mul_b;
  logic [2*WIDTH-1:0] mul_product;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic               rd_valid;
  logic [WIDTH-1:0]   rd_data;

  int n_tests = 0;
  int n_fail  = 0;
  int last_gap = 0;

  logic [WIDTH-1:0]   rd_q[$];
  logic [2*WIDTH-1:0] mul_q[$];

  mult_hilo_ctrl #(.WIDTH(WIDTH), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code),
    .op_rs(op_rs), .op_rt(op_rt), .stall(stall), .busy(busy),
    .mul_en(mul_en), .mul_a(mul_a), .mul_b(mul_b),
    .mul_product(mul_product), .hi(hi), .lo(lo),
    .rd_valid(rd_valid), .rd_data(rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiplier model: product becomes valid after MUL_LAT enabled cycles
  int ecnt = 0;
  always @(posedge clk) begin
    if (!mul_en) begin
      ecnt        <= 0;
      mul_product <= 64'hDEAD_BEEF_DEAD_BEEF;
    end else begin
      ecnt <= ecnt + 1;
      if (ecnt + 1 >= MUL_LAT) mul_product <= 64'(mul_a) * 64'(mul_b);
      else                     mul_product <= 64'hBAD0_BAD0_BAD0_BAD0;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: scoreboard pops plus enable/busy run-length checks
  initial begin
    logic prev_busy = 1'b0;
    logic prev_en   = 1'b0;
    int   busy_run  = 0;
    int   en_run    = 0;
    int   low_cnt   = 0;
    logic [2*WIDTH-1:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_busy = 1'b0; prev_en = 1'b0;
        busy_run = 0; en_run = 0; low_cnt = 0;
      end else begin
        if (rd_valid) begin
          if (rd_q.size() == 0) chk("rd_unexpected", 64'd1, 64'd0);
          else chk("rd_data", 64'(rd_data), 64'(rd_q.pop_front()));
        end
        if (busy) begin
          busy_run++;
        end else if (prev_busy) begin
          chk("busy_len", 64'(busy_run), 64'(MUL_LAT + 1));
          busy_run = 0;
          if (mul_q.size() == 0) chk("capture_unexpected", 64'd1, 64'd0);
          else begin
            e = mul_q.pop_front();
            chk("hilo_product", {hi, lo}, e);
          end
        end
        if (mul_en) begin
          if (!prev_en) last_gap = low_cnt;
          en_run++;
          low_cnt = 0;
        end else begin
          if (prev_en) begin
            chk("mul_en_len", 64'(en_run), 64'(MUL_LAT + 1));
            en_run = 0;
          end
          low_cnt++;
        end
        prev_busy = busy;
        prev_en   = mul_en;
      end
    end
  end

  // Present an op at posedge+1 and hold it until accepted; returns at
  // posedge+1 after the accepting edge with the op still driven.
  task automatic send(input logic [2:0] code, input logic [31:0] rs,
                      input logic [31:0] rt, output int stalls);
    op_valid = 1'b1; op_code = code; op_rs = rs; op_rt = rt;
    stalls = 0;
    @(negedge clk);
    while (stall && stalls < 200) begin
      stalls++;
      @(negedge clk);
    end
    if (stall) chk("accept_timeout", 64'd1, 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic idle_op();
    op_valid = 1'b0; op_code = OP_NONE; op_rs = '0; op_rt = '0;
  endtask

  task automatic multu(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el, output int stalls);
    mul_q.push_back({eh, el});
    send(OP_MULTU, a, b, stalls);
  endtask

  task automatic rd(input logic [2:0] code, input logic [31:0] exp, output int stalls);
    rd_q.push_back(exp);
    send(code, 32'd0, 32'd0, stalls);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (busy) chk("idle_timeout", 64'd1, 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int s;
    rst = 1'b1;
    idle_op();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mul_en", 64'(mul_en), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    chk("rst_rd", {31'd0, rd_valid, rd_data}, 64'd0);
    chk("rst_mul_ab", {mul_a, mul_b}, 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // MULTU 0xFFFFFFFF * 2 = 0x1_FFFFFFFE
    multu(32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, s);
    chk("t2_accept_stalls", 64'(s), 64'd0);
    idle_op();
    wait_idle();
    chk("t2_hi", 64'(hi), 64'h0000_0001);
    chk("t2_lo", 64'(lo), 64'hFFFF_FFFE);
    rd(OP_MFLO, 32'hFFFF_FFFE, s);
    idle_op();
    repeat (3) @(posedge clk);
    #1;
    chk("rd_data_held", 64'(rd_data), 64'hFFFF_FFFE);
    chk("rd_valid_low", 64'(rd_valid), 64'd0);

    // Reset asserted mid-RUN with cnt == 10
    send(OP_MULTU, 32'd3, 32'd4, s);
    idle_op();
    repeat (10) @(posedge clk);
    #1;
    chk("t1_cnt10", 64'(dut.cnt_r), 64'd10);
    rst = 1'b1;
    #1;
    chk("t1_mul_en", 64'(mul_en), 64'd0);
    chk("t1_busy", 64'(busy), 64'd0);
    chk("t1_hilo", {hi, lo}, 64'd0);
    chk("t1_rd_data", 64'(rd_data), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (MUL_LAT + 5) @(posedge clk);
    #1;
    chk("t1_no_capture", {hi, lo}, 64'd0);
    chk("t1_still_idle", {62'd0, busy, mul_en}, 64'd0);

    // MULTU then MFLO next cycle: stalled through DONE, returns new low
    multu(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, s);
    rd(OP_MFLO, 32'h0000_0001, s);
    chk("t3_mflo_stalls", 64'(s), 64'(MUL_LAT + 1));
    idle_op();
    @(posedge clk); #1;

    // MTHI then MFHI; MTLO during busy waits for capture
    send(OP_MTHI, 32'h0000_1234, 32'd0, s);
    chk("t4_mthi_stalls", 64'(s), 64'd0);
    rd(OP_MFHI, 32'h0000_1234, s);
    multu(32'd3, 32'd5, 32'd0, 32'h0000_000F, s);
    send(OP_MTLO, 32'h0000_A5A5, 32'd0, s);
    chk("t4_mtlo_stalls", 64'(s), 64'(MUL_LAT + 1));
    rd(OP_MFLO, 32'h0000_A5A5, s);
    rd(OP_MFHI, 32'h0000_0000, s);
    idle_op();
    @(posedge clk); #1;
    chk("t4_final_lo", 64'(lo), 64'h0000_A5A5);

    // Back-to-back MULTU
    multu(32'h0001_0000, 32'h0001_0001, 32'h0000_0001, 32'h0001_0000, s);
    multu(32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_0000, 32'hFFFE_0001, s);
    chk("t5_second_stalls", 64'(s), 64'(MUL_LAT + 1));
    idle_op();
    wait_idle();
    chk("t5_en_gap", 64'(last_gap), 64'd1);
    chk("t5_hilo", {hi, lo}, 64'h0000_0000_FFFE_0001);
    chk("t5_mul_ab_held", {mul_a, mul_b}, 64'h0000_FFFF_0000_FFFF);

    // Ignored op codes, idle and busy
    send(OP_R7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, s);
    chk("t6_idle_r7_stall", 64'(s), 64'd0);
    send(OP_NONE, 32'hFFFF_FFFF, 32'd7, s);
    chk("t6_idle_none_stall", 64'(s), 64'd0);
    send(OP_R6, 32'h1111_1111, 32'd7, s);
    chk("t6_idle_r6_stall", 64'(s), 64'd0);
    chk("t6_idle_state", {hi, lo, 31'd0, busy}, {32'h0, 32'hFFFE_0001, 32'd0});
    multu(32'd7, 32'd6, 32'd0, 32'h0000_002A, s);
    send(OP_R7, 32'hFFFF_FFFF, 32'd0, s);
    chk("t6_busy_r7_stall", 64'(s), 64'd0);
    send(OP_NONE, 32'hFFFF_FFFF, 32'd0, s);
    chk("t6_busy_none_stall", 64'(s), 64'd0);
    chk("t6_busy_kept", 64'(busy), 64'd1);
    idle_op();
    wait_idle();
    chk("t6_hilo", {hi, lo}, 64'h0000_0000_0000_002A);

    repeat (3) @(posedge clk);
    chk("rd_q_empty", 64'(rd_q.size()), 64'd0);
    chk("mul_q_empty", 64'(mul_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
